change_dispenser: RTL
=====================

CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 SHALL have parameter INIT_COUNT, default 10, coins loaded into each tube at reset.
REQ-002 SHALL have parameter MAX_COUNT, default 31, tube capacity; restock saturates here.
REQ-003 SHALL have parameter ACK_TIMEOUT, default 15, max cycles waiting for coin_ack before jam.
REQ-004 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port refund_valid  input  1  refund request present.
REQ-007 SHALL have port refund_amount  input  7  refund value in rupees, 0-127.
REQ-008 SHALL have port ready  output  1  high only in IDLE; request accepted when refund_valid&&ready.
REQ-009 SHALL have port coin_valid  output  1  eject request to coin motor.
REQ-010 SHALL have port coin_type  output  2  00=Rs1, 01=Rs2, 10=Rs5; 11 never driven while coin_valid=1.
REQ-011 SHALL have port coin_ack  input  1  motor confirms one coin ejected.
REQ-012 SHALL have port restock_valid  input  1  one coin added to a tube this cycle.
REQ-013 SHALL have port restock_type  input  2  tube for restock, same encoding as coin_type; 11 ignored.
REQ-014 SHALL have port done  output  1  one-cycle pulse, refund finished.
REQ-015 SHALL have port shortfall  output  7  unpaid rupees; valid from done pulse until next accept.
REQ-016 SHALL have port jam  output  1  sticky motor-timeout flag.
REQ-017 SHALL have port tube_empty  output  3  bit0=Rs1, bit1=Rs2, bit2=Rs5 tube count==0.

Function
REQ-018 SHALL implement states IDLE, SELECT, EJECT, DONE; all outputs registered or decoded from state.
REQ-019 SHALL, in IDLE with refund_valid=1, capture refund_amount into 7-bit remaining and go to SELECT next cycle; refund_valid ignored outside IDLE.
REQ-020 SHALL, in SELECT (one cycle), choose greedily: Rs5 if remaining>=5 and cnt5>0; else Rs2 if remaining>=2 and cnt2>0; else Rs1 if remaining>=1 and cnt1>0; then go to EJECT.
REQ-021 SHALL, in SELECT with no choice possible, go to DONE with shortfall=remaining (0 when fully paid).
REQ-022 SHALL, in EJECT, hold coin_valid=1 and coin_type stable until coin_ack=1 sampled; then decrement remaining by coin value and that tube count by 1, and return to SELECT.
REQ-023 SHALL give latency: accept at cycle T, first coin_valid at T+2; ack at cycle A, coin_valid low at A+1, next coin_valid at A+2.
REQ-024 SHALL ignore coin_ack outside EJECT.
REQ-025 SHALL count EJECT cycles; if ACK_TIMEOUT cycles pass without coin_ack, set jam=1, drop coin_valid, go to DONE with shortfall=remaining.
REQ-026 SHALL, while jam=1, accept requests but go to DONE immediately with shortfall=refund_amount, ejecting nothing.
REQ-027 SHALL, in DONE, assert done=1 for one cycle and return to IDLE next cycle.
REQ-028 SHALL handle amount 0 as IDLE->SELECT->DONE with shortfall=0 and no coin.
REQ-029 SHALL apply restock in any state: increment the selected tube, saturating at MAX_COUNT.
REQ-030 SHALL, on restock and ack-decrement of the same tube in one cycle, leave the count unchanged.
REQ-031 SHALL use 5-bit tube counters; counts never wrap below 0 or above MAX_COUNT.

Reset
REQ-032 SHALL, on reset, force IDLE, ready=1, coin_valid=0, coin_type=00, done=0, shortfall=0, jam=0, remaining=0, all tubes=INIT_COUNT, tube_empty=000.
REQ-033 SHALL, on reset mid-refund, abandon the refund without done pulse; unpaid value is lost.

Verification
REQ-034 SHALL verify amount 13, ack one cycle after each coin_valid -> coins 5,5,2,1; done with shortfall=0; cnt5=8, cnt2=9, cnt1=9.
REQ-035 SHALL verify cnt5=0 (preloaded via reset then drained), amount 7 -> coins 2,2,2,1; shortfall=0.
REQ-036 SHALL verify cnt1=0, cnt2=0, amount 6 -> coin 5 then done with shortfall=1 (greedy, no backtrack).
REQ-037 SHALL verify coin_ack never asserted, amount 5 -> coin_valid high 15 cycles, then jam=1, done with shortfall=5; next request amount 3 -> done, shortfall=3, no coin.
REQ-038 SHALL verify restock Rs1 32 times from 10 -> cnt1=31 saturated; restock Rs1 coinciding with Rs1 ack -> count unchanged.
REQ-039 SHALL verify reset asserted during EJECT -> coin_valid=0, ready=1, tubes=10, no done pulse.

Source files
------------

// File: rtl/change_dispenser.sv
// Coin change dispenser: greedy Rs5/Rs2/Rs1 payout from three tubes, with a
// motor handshake, a sticky jam flag on ack timeout, and saturating restock.
module change_dispenser #(
    parameter int INIT_COUNT  = 10,
    parameter int MAX_COUNT   = 31,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       refund_valid,
    input  logic [6:0] refund_amount,
    output logic       ready,
    output logic       coin_valid,
    output logic [1:0] coin_type,
    input  logic       coin_ack,
    input  logic       restock_valid,
    input  logic [1:0] restock_type,
    output logic       done,
    output logic [6:0] shortfall,
    output logic       jam,
    output logic [2:0] tube_empty
);
    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [4:0]    INIT_CNT   = 5'(INIT_COUNT);
    localparam logic [4:0]    MAX_CNT    = 5'(MAX_COUNT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_SELECT, S_EJECT, S_DONE} state_e;

    state_e          state_q, state_d;
    logic [6:0]      remaining_q, remaining_d;
    logic [6:0]      shortfall_q, shortfall_d;
    logic [1:0]      coin_type_q, coin_type_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            jam_q, jam_d;
    // Tube index matches the coin_type encoding: 0=Rs1, 1=Rs2, 2=Rs5.
    logic [2:0][4:0] cnt_q, cnt_d;
    logic            ack_take;
    logic [6:0]      coin_value;

    // NOTE: the tube counters are ordinary flops, so they take a reset value like every other register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            shortfall_q <= '0;
            coin_type_q <= 2'b00;
            timer_q     <= '0;
            jam_q       <= 1'b0;
            cnt_q       <= {3{INIT_CNT}};
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            remaining_q <= remaining_d;
            shortfall_q <= shortfall_d;
            coin_type_q <= coin_type_d;
            timer_q     <= timer_d;
            jam_q       <= jam_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        case (coin_type_q)
            2'b10:   coin_value = 7'd5;
            2'b01:   coin_value = 7'd2;
            default: coin_value = 7'd1;
        endcase
    end

    always_comb begin
        // NOTE: defaults first, so no path through the case leaves a signal unassigned (no latch).
        state_d     = state_q;
        remaining_d = remaining_q;
        shortfall_d = shortfall_q;
        coin_type_d = coin_type_q;
        timer_d     = timer_q;
        jam_d       = jam_q;
        ack_take    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (refund_valid) begin
                    if (jam_q) begin
                        shortfall_d = refund_amount;
                        state_d     = S_DONE;
                    end else begin
                        remaining_d = refund_amount;
                        state_d     = S_SELECT;
                    end
                end
            end
            S_SELECT: begin
                timer_d = '0;
                state_d = S_EJECT;
                if (remaining_q >= 7'd5 && cnt_q[2] != 5'd0) begin
                    coin_type_d = 2'b10;
                end else if (remaining_q >= 7'd2 && cnt_q[1] != 5'd0) begin
                    coin_type_d = 2'b01;
                end else if (remaining_q >= 7'd1 && cnt_q[0] != 5'd0) begin
                    coin_type_d = 2'b00;
                end else begin
                    shortfall_d = remaining_q;
                    state_d     = S_DONE;
                end
            end
            S_EJECT: begin
                if (coin_ack) begin
                    ack_take    = 1'b1;
                    remaining_d = remaining_q - coin_value;
                    state_d     = S_SELECT;
                end else if (timer_q == TIMER_LAST) begin
                    jam_d       = 1'b1;
                    shortfall_d = remaining_q;
                    state_d     = S_DONE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A restock and an ack-decrement on the same tube cancel out.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = cnt_q[i];
            if (restock_valid && restock_type == 2'(i)) begin
                if (!(ack_take && coin_type_q == 2'(i)) && cnt_q[i] < MAX_CNT) begin
                    cnt_d[i] = cnt_q[i] + 5'd1;
                end
            end else if (ack_take && coin_type_q == 2'(i) && cnt_q[i] != 5'd0) begin
                cnt_d[i] = cnt_q[i] - 5'd1;
            end
        end
    end

    always_comb begin
        ready      = (state_q == S_IDLE);
        coin_valid = (state_q == S_EJECT);
        done       = (state_q == S_DONE);
        coin_type  = coin_type_q;
        shortfall  = shortfall_q;
        jam        = jam_q;
        for (int i = 0; i < 3; i++) begin
            tube_empty[i] = (cnt_q[i] == 5'd0);
        end
    end
endmodule
